uart_rx: RTL and testbench

Bus slave that receives the serial stream produced by `uart_tx` (or an external host) on `RxD` and buffers received bytes in a FIFO for the CPU to read. It sits on the same shared tri-state bus as `uart_tx`, at its own address window directly below it. It uses 8x oversampling with mid-bit sampling, 8N1 framing, and sticky overrun and framing-error flags.

---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Request side of the shared CPU bus as seen by a peripheral; the tri-state
// data and ready lines stay on the peripheral itself.
interface uart_rx_if;
  logic [31:0] address;
  logic        request;
  logic        r_w;

  modport master (output address, request, r_w);
  modport slave  (input  address, request, r_w);
endinterface

// File: rtl/uart_rx.sv
// 8x-oversampled 8N1 receiver feeding a byte FIFO behind a zero-wait-state bus window.
// Bytes land one cycle after the stop sample; a byte arriving with the FIFO full is dropped and flags overrun.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 1500000,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] BASE       = 32'h3fffffe0
) (
  input  logic        clk,
  input  logic        rst,
  uart_rx_if.slave    bus,
  inout  wire  [31:0] data,
  output wire         ready_out,
  input  logic        RxD,
  output logic        RxD_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [32:0] INC    = 33'(BAUD) * 33'(OVERSAMPLE);
  localparam logic [32:0] CLK_HZ = 33'(CLK_FREQ);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rxState_t;

  rxState_t    state, stateNext;
  logic        rxMeta, rxSync;
  logic [32:0] tickAcc, accSum;
  logic        tick, restartTick;
  logic [2:0]  tickCnt, tickCntNext, bitCnt, bitCntNext;
  logic [7:0]  shiftReg, shiftNext;
  logic        push, setFrameErr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          full, notEmpty, pushAcc, overflow;
  logic          frameErr, overrun;

  logic        inWindow, sel, selD, firstCyc, pop, wrCtrl, flush, clrFlags;
  logic [1:0]  idx;
  logic [31:0] rdData;
  logic        unusedData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= RxD;
      rxSync <= rxMeta;
    end
  end

  // Fractional accumulator: average tick rate is exactly BAUD*OVERSAMPLE.
  always_comb begin
    accSum = tickAcc + INC;
    tick   = (accSum >= CLK_HZ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              tickAcc <= '0;
    else if (restartTick) tickAcc <= '0;
    else if (tick)        tickAcc <= accSum - CLK_HZ;
    else                  tickAcc <= accSum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tickCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
    end else begin
      state    <= stateNext;
      tickCnt  <= tickCntNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftNext;
    end
  end

  always_comb begin
    stateNext   = state;
    tickCntNext = tickCnt;
    bitCntNext  = bitCnt;
    shiftNext   = shiftReg;
    restartTick = 1'b0;
    push        = 1'b0;
    setFrameErr = 1'b0;
    case (state)
      IDLE: begin
        if (!rxSync) begin
          restartTick = 1'b1;
          tickCntNext = '0;
          stateNext   = START;
        end
      end
      START: begin
        // Fourth tick is mid start bit; a line back high here was a glitch.
        if (tick) begin
          tickCntNext = tickCnt + 3'd1;
          if (tickCnt == 3'd3) begin
            tickCntNext = '0;
            bitCntNext  = '0;
            stateNext   = rxSync ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tickCntNext = tickCnt + 3'd1;
          if (tickCnt == 3'd7) begin
            shiftNext  = {rxSync, shiftReg[7:1]};
            bitCntNext = bitCnt + 3'd1;
            if (bitCnt == 3'd7) stateNext = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tickCntNext = tickCnt + 3'd1;
          if (tickCnt == 3'd7) begin
            if (rxSync) begin
              push      = 1'b1;
              stateNext = IDLE;
            end else begin
              setFrameErr = 1'b1;
              stateNext   = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (rxSync) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign inWindow = ({1'b0, bus.address} >= {1'b0, BASE}) &&
                    ({1'b0, bus.address} <= ({1'b0, BASE} + 33'd15));
  assign sel      = bus.request & inWindow;
  assign firstCyc = sel & ~selD;
  assign idx      = bus.address[1:0];
  assign pop      = firstCyc & ~bus.r_w & (idx == 2'd0) & notEmpty;
  assign wrCtrl   = firstCyc & bus.r_w & (idx == 2'd2);
  assign flush    = wrCtrl & data[1];
  assign clrFlags = wrCtrl & data[0];
  assign unusedData = ^data[31:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) selD <= 1'b0;
    else     selD <= sel;
  end

  assign full     = (count == CW'(FIFO_DEPTH));
  assign notEmpty = (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign pushAcc  = push & (~full | pop);
  assign overflow = push & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (pushAcc && !flush) mem[wrPtr] <= shiftReg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushAcc) wrPtr <= wrPtr + PW'(1);
      if (pop)     rdPtr <= rdPtr + PW'(1);
      case ({pushAcc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (clrFlags) begin
        frameErr <= 1'b0;
        overrun  <= 1'b0;
      end
      if (setFrameErr) frameErr <= 1'b1;
      if (overflow)    overrun  <= 1'b1;
    end
  end

  always_comb begin
    rdData = '0;
    case (idx)
      2'd0:    if (notEmpty) rdData = {23'b0, 1'b1, mem[rdPtr]};
      2'd1:    rdData = {15'b0, (state != IDLE), 8'(count), 4'b0,
                         frameErr, overrun, full, notEmpty};
      default: rdData = '0;
    endcase
  end

  assign data      = (sel && !bus.r_w) ? rdData : 32'bz;
  assign ready_out = sel ? 1'b1 : 1'bz;
  assign RxD_ready = notEmpty;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: queue-based receive model plus literal expectations.
module tb_uart_rx;
  localparam int unsigned CLK_FREQ = 16;
  localparam int unsigned BAUD     = 1;
  localparam int unsigned DEPTH    = 16;
  localparam logic [31:0] BASE     = 32'h3fffffe0;
  localparam int          BITC     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RxD = 1'b1;
  logic        RxD_ready;
  wire  [31:0] data;
  wire         ready_out;
  logic [31:0] drvDat = '0;
  logic        drvEn  = 1'b0;

  assign data = drvEn ? drvDat : 32'bz;

  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(8), .FIFO_DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .data(data), .ready_out(ready_out),
    .RxD(RxD), .RxD_ready(RxD_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] mq[$];
  bit mOverrun = 0, mFrameErr = 0, mBusy = 0, quiet = 0;
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [1:0] idx);
    logic [31:0] r;
    r = '0;
    if (idx == 2'd0 && mq.size() > 0) r = {23'b0, 1'b1, mq[0]};
    else if (idx == 2'd1)
      r = {15'b0, mBusy, 8'(mq.size()), 4'b0, mFrameErr, mOverrun,
           (mq.size() == DEPTH), (mq.size() != 0)};
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.request) begin
        check("ready_out", {31'b0, ready_out}, 32'd1);
        if (!bus.r_w) check("read_data", data, modelRead(bus.address[1:0]));
      end
      if (quiet) check("RxD_ready", {31'b0, RxD_ready}, {31'b0, (mq.size() != 0)});
    end
  end

  task automatic busRead(input logic [1:0] idx, input int hold, output logic [31:0] val);
    @(posedge clk); #1;
    bus.address = BASE + 32'(idx);
    bus.r_w     = 1'b0;
    bus.request = 1'b1;
    @(negedge clk);
    val = data;
    @(posedge clk);
    if (idx == 2'd0 && mq.size() > 0) void'(mq.pop_front());
    repeat (hold - 1) @(posedge clk);
    #1 bus.request = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    bus.address = BASE + 32'(idx);
    bus.r_w     = 1'b1;
    bus.request = 1'b1;
    drvDat      = val;
    drvEn       = 1'b1;
    @(posedge clk);
    if (idx == 2'd2) begin
      if (val[0]) begin
        mOverrun  = 0;
        mFrameErr = 0;
      end
      if (val[1]) mq.delete();
    end
    #1;
    bus.request = 1'b0;
    bus.r_w     = 1'b0;
    drvEn       = 1'b0;
  endtask

  // Start edge at P0+1; the receiver samples the stop bit at P155, so a read
  // issued at P154+1 pops on the same edge as the push.
  task automatic sendFrame(input logic [7:0] b, input bit stopVal, input int stopBits, input bit popInStop);
    logic [31:0] v;
    quiet = 0;
    @(posedge clk); #1 RxD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BITC) @(posedge clk);
      #1 RxD = b[i];
    end
    repeat (BITC) @(posedge clk);
    #1 RxD = stopVal;
    if (popInStop) begin
      repeat (9) @(posedge clk);
      busRead(2'd0, 1, v);
      repeat (BITC * stopBits - 11) @(posedge clk);
    end else begin
      repeat (BITC * stopBits) @(posedge clk);
    end
    #1 RxD = 1'b1;
    repeat (4) @(posedge clk);
    if (stopVal) begin
      if (mq.size() == DEPTH) mOverrun = 1;
      else mq.push_back(b);
    end else begin
      mFrameErr = 1;
    end
    quiet = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  burst    [4] = '{8'h00, 8'h55, 8'hFF, 8'h80};
    logic [31:0] burstExp [4] = '{32'h100, 32'h155, 32'h1FF, 32'h180};

    bus.address = '0;
    bus.request = 1'b0;
    bus.r_w     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rxready", {31'b0, RxD_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    quiet = 1;
    busRead(2'd1, 1, v); check("reset_status", v, 32'h0);

    sendFrame(8'hA5, 1, 1, 0);
    check("a5_rxready", {31'b0, RxD_ready}, 32'd1);
    busRead(2'd1, 1, v); check("a5_status", v, 32'h101);
    busRead(2'd0, 1, v); check("a5_data", v, 32'h1A5);
    busRead(2'd1, 1, v); check("a5_status_after", v, 32'h0);

    for (int i = 0; i < 4; i++) sendFrame(burst[i], 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      busRead(2'd0, 1, v); check("burst_data", v, burstExp[i]);
    end
    busRead(2'd0, 1, v); check("burst_empty_read", v, 32'h0);

    for (int i = 1; i <= 17; i++) sendFrame(8'(i), 1, 1, 0);
    busRead(2'd1, 1, v); check("ovr_status", v, 32'h1007);
    for (int i = 1; i <= 16; i++) begin
      busRead(2'd0, 1, v); check("ovr_data", v, 32'h100 + 32'(i));
    end
    busRead(2'd1, 1, v); check("ovr_sticky", v, 32'h4);
    busWrite(2'd2, 32'h1);
    busRead(2'd1, 1, v); check("ovr_cleared", v, 32'h0);

    sendFrame(8'h3C, 0, 2, 0);
    sendFrame(8'h42, 1, 1, 0);
    busRead(2'd1, 1, v); check("fe_status", v, 32'h109);
    busRead(2'd0, 1, v); check("fe_data", v, 32'h142);
    busRead(2'd1, 1, v); check("fe_sticky", v, 32'h8);
    busWrite(2'd2, 32'h1);

    quiet = 0;
    @(posedge clk); #1 RxD = 1'b0;
    repeat (4) @(posedge clk);
    #1 RxD = 1'b1;
    mBusy = 1;
    busRead(2'd1, 1, v); check("glitch_busy", v, 32'h10000);
    mBusy = 0;
    repeat (8) @(posedge clk);
    busRead(2'd1, 1, v); check("glitch_idle", v, 32'h0);
    quiet = 1;

    sendFrame(8'h11, 1, 1, 0);
    sendFrame(8'h22, 1, 1, 0);
    busRead(2'd0, 5, v); check("held_data", v, 32'h111);
    busRead(2'd1, 1, v); check("held_status", v, 32'h101);
    busRead(2'd0, 1, v); check("held_next", v, 32'h122);

    sendFrame(8'h99, 1, 1, 0);
    busWrite(2'd2, 32'h2);
    busRead(2'd1, 1, v); check("flush_status", v, 32'h0);

    for (int i = 0; i < 16; i++) sendFrame(8'h30 + 8'(i), 1, 1, 0);
    sendFrame(8'h77, 1, 1, 1);
    busRead(2'd1, 1, v); check("popfull_status", v, 32'h1003);
    for (int i = 1; i < 16; i++) begin
      busRead(2'd0, 1, v); check("popfull_data", v, 32'h130 + 32'(i));
    end
    busRead(2'd0, 1, v); check("popfull_last", v, 32'h177);

    sendFrame(8'h5A, 1, 1, 0);
    quiet = 0;
    @(posedge clk); #1 RxD = 1'b0;
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    mq.delete();
    mOverrun  = 0;
    mFrameErr = 0;
    repeat (2) @(posedge clk);
    #1;
    RxD = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    quiet = 1;
    @(negedge clk);
    check("rst_rxready", {31'b0, RxD_ready}, 32'd0);
    busRead(2'd1, 1, v); check("rst_status", v, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
